// File: rtl/morse_pkg.sv
// Shared types and letter table for the Morse transmitter.
// Codes are MSB-aligned, bit=1 is a dash, bit=0 is a dot.
package morse_pkg;

  localparam int LEN_W  = 3;
  localparam int CODE_W = 4;
  localparam int UNIT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MARK  = 3'd2,
    S_SPACE = 3'd3,
    S_LGAP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [CODE_W-1:0] code;
  } morse_ent_t;

  function automatic morse_ent_t morse_lookup(
    input logic [4:0] idx
  );
    morse_ent_t e;
    e = '{len: '0, code: '0};
    case (idx)
      5'd0:  e = '{3'd2, 4'b0100};
      5'd1:  e = '{3'd4, 4'b1000};
      5'd2:  e = '{3'd4, 4'b1010};
      5'd3:  e = '{3'd3, 4'b1000};
      5'd4:  e = '{3'd1, 4'b0000};
      5'd5:  e = '{3'd4, 4'b0010};
      5'd6:  e = '{3'd3, 4'b1100};
      5'd7:  e = '{3'd4, 4'b0000};
      5'd8:  e = '{3'd2, 4'b0000};
      5'd9:  e = '{3'd4, 4'b0111};
      5'd10: e = '{3'd3, 4'b1010};
      5'd11: e = '{3'd4, 4'b0100};
      5'd12: e = '{3'd2, 4'b1100};
      5'd13: e = '{3'd2, 4'b1000};
      5'd14: e = '{3'd3, 4'b1110};
      5'd15: e = '{3'd4, 4'b0110};
      5'd16: e = '{3'd4, 4'b1101};
      5'd17: e = '{3'd3, 4'b0100};
      5'd18: e = '{3'd3, 4'b0000};
      5'd19: e = '{3'd1, 4'b1000};
      5'd20: e = '{3'd3, 4'b0010};
      5'd21: e = '{3'd4, 4'b0001};
      5'd22: e = '{3'd3, 4'b0110};
      5'd23: e = '{3'd4, 4'b1001};
      5'd24: e = '{3'd4, 4'b1011};
      5'd25: e = '{3'd4, 4'b1100};
      default: e = '{len: '0, code: '0};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Tick prescaler plus unit counter; both clear on clr so
// every FSM phase starts from a clean count.
module morse_unit_timer
  import morse_pkg::*;
#(
  parameter int CLK_PER_UNIT = 25_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              unit_stb,
  output logic [UNIT_W-1:0] unit_cnt
);

  localparam int TICK_W =
    (CLK_PER_UNIT > 1) ? $clog2(CLK_PER_UNIT) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX =
    TICK_W'(CLK_PER_UNIT - 1);

  logic [TICK_W-1:0] tick;

  assign unit_stb = (tick == TICK_MAX);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tick     <= '0;
      unit_cnt <= '0;
    end else if (unit_stb) begin
      tick     <= '0;
      unit_cnt <= unit_cnt + UNIT_W'(1);
    end else begin
      tick     <= tick + TICK_W'(1);
    end
  end

endmodule

// File: rtl/morse_tx_gen.sv
// Morse letter transmitter: one latched letter per start,
// optional repeat, registered tone/busy/done/display outputs.
module morse_tx_gen
  import morse_pkg::*;
#(
  parameter int CLK_PER_UNIT = 25_000_000,
  parameter int SEL_W        = 3,
  parameter int DASH_UNITS   = 3,
  parameter int LGAP_UNITS   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] sel,
  input  logic             start,
  input  logic             stop,
  input  logic             repeat_en,
  output logic             tone,
  output logic             busy,
  output logic             done,
  output logic [4:0]       letter,
  output logic [2:0]       sym_left
);

  localparam logic [UNIT_W-1:0] DASH_LAST =
    UNIT_W'(DASH_UNITS - 1);
  localparam logic [UNIT_W-1:0] LGAP_LAST =
    UNIT_W'(LGAP_UNITS - 1);

  state_t            state;
  logic [CODE_W-1:0] code_q;
  morse_ent_t        ent;
  logic              timed;
  logic              unit_stb;
  logic              phase_end;
  logic              tmr_clr;
  logic [UNIT_W-1:0] unit_cnt;
  logic [UNIT_W-1:0] unit_last;

  assign ent   = morse_lookup(letter);
  assign timed = (state == S_MARK) ||
                 (state == S_SPACE) ||
                 (state == S_LGAP);

  always_comb begin
    unit_last = '0;
    unique case (1'b1)
      (state == S_MARK && code_q[CODE_W-1]):
        unit_last = DASH_LAST;
      (state == S_LGAP):
        unit_last = LGAP_LAST;
      default:
        unit_last = '0;
    endcase
  end

  assign phase_end = timed && unit_stb &&
                     (unit_cnt == unit_last);
  // Holding the timer cleared outside timed states makes
  // each phase start exactly on its entry edge.
  assign tmr_clr = !timed || phase_end;

  morse_unit_timer #(
    .CLK_PER_UNIT(CLK_PER_UNIT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .unit_stb(unit_stb),
    .unit_cnt(unit_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      code_q   <= '0;
      tone     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      letter   <= '0;
      sym_left <= '0;
    end else begin
      done <= 1'b0;
      if (state != S_IDLE && stop) begin
        state    <= S_IDLE;
        tone     <= 1'b0;
        busy     <= 1'b0;
        sym_left <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start && !stop) begin
              state  <= S_LOAD;
              busy   <= 1'b1;
              letter <= 5'(sel);
            end
          end
          S_LOAD: begin
            if (ent.len == '0) begin
              state    <= S_DONE;
              done     <= 1'b1;
              sym_left <= '0;
            end else begin
              state    <= S_MARK;
              tone     <= 1'b1;
              sym_left <= ent.len;
              code_q   <= ent.code;
            end
          end
          S_MARK: begin
            if (phase_end) begin
              tone     <= 1'b0;
              sym_left <= sym_left - 3'd1;
              code_q   <= {code_q[CODE_W-2:0], 1'b0};
              state    <= (sym_left == 3'd1) ?
                          S_LGAP : S_SPACE;
            end
          end
          S_SPACE: begin
            if (phase_end) begin
              tone  <= 1'b1;
              state <= S_MARK;
            end
          end
          S_LGAP: begin
            if (phase_end) begin
              if (repeat_en) begin
                state <= S_LOAD;
              end else begin
                state <= S_DONE;
                done  <= 1'b1;
              end
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
